// File: rtl/rv32_bus_arbiter_if.sv
// Signal bundle between the RV32I data-bus arbiter, its two masters and the shared slave.
// The slave modport is the arbiter's view; master is the view of the requesters and slave model.
interface rv32_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0Req;
  logic              m0We;
  logic [ADDR_W-1:0] m0Addr;
  logic [DATA_W-1:0] m0WData;
  logic [DATA_W-1:0] m0RData;
  logic              m0Ready;
  logic              m0Err;

  logic              m1Req;
  logic              m1We;
  logic [ADDR_W-1:0] m1Addr;
  logic [DATA_W-1:0] m1WData;
  logic [DATA_W-1:0] m1RData;
  logic              m1Ready;
  logic              m1Err;

  logic              sReq;
  logic              sWe;
  logic [ADDR_W-1:0] sAddr;
  logic [DATA_W-1:0] sWData;
  logic [DATA_W-1:0] sRData;
  logic              sReady;

  modport slave (
    input  m0Req, m0We, m0Addr, m0WData,
    input  m1Req, m1We, m1Addr, m1WData,
    input  sRData, sReady,
    output m0RData, m0Ready, m0Err,
    output m1RData, m1Ready, m1Err,
    output sReq, sWe, sAddr, sWData
  );

  modport master (
    output m0Req, m0We, m0Addr, m0WData,
    output m1Req, m1We, m1Addr, m1WData,
    output sRData, sReady,
    input  m0RData, m0Ready, m0Err,
    input  m1RData, m1Ready, m1Err,
    input  sReq, sWe, sAddr, sWData
  );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Round-robin two-master / one-slave arbiter for the RV32I data bus with a slave timeout.
// One transfer in flight at a time: IDLE -> BUSY -> RESP -> IDLE, all outputs decoded from registers.
module rv32_bus_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input logic               clk,
  input logic               reset,
  rv32_bus_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              grant;
  logic              last_grant;
  logic              pick;
  logic              any_req;
  logic              done;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] resp_data;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  // On a tie the master that was not served last wins; otherwise the lone requester.
  assign any_req   = bus.m0Req | bus.m1Req;
  assign pick      = (bus.m0Req & bus.m1Req) ? ~last_grant : ~bus.m0Req;
  assign done      = bus.sReady | (cnt == CNT_LAST);
  assign resp_data = bus.sReady ? bus.sRData : ERR_DATA;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (done)    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            grant   <= pick;
            we_q    <= pick ? bus.m1We    : bus.m0We;
            addr_q  <= pick ? bus.m1Addr  : bus.m0Addr;
            wdata_q <= pick ? bus.m1WData : bus.m0WData;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // A ready on the final counted cycle takes priority over the timeout.
          if (done) begin
            err_q <= ~bus.sReady;
            if (grant) begin
              rdata1_q <= resp_data;
            end else begin
              rdata0_q <= resp_data;
            end
          end
        end
        RESP: begin
          last_grant <= grant;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.sReq    = 1'b0;
    bus.sWe     = 1'b0;
    bus.sAddr   = '0;
    bus.sWData  = '0;
    bus.m0Ready = 1'b0;
    bus.m0Err   = 1'b0;
    bus.m1Ready = 1'b0;
    bus.m1Err   = 1'b0;
    case (state)
      BUSY: begin
        bus.sReq   = 1'b1;
        bus.sWe    = we_q;
        bus.sAddr  = addr_q;
        bus.sWData = wdata_q;
      end
      RESP: begin
        if (grant) begin
          bus.m1Ready = 1'b1;
          bus.m1Err   = err_q;
        end else begin
          bus.m0Ready = 1'b1;
          bus.m0Err   = err_q;
        end
      end
      default: begin
        bus.sReq = 1'b0;
      end
    endcase
  end

  assign bus.m0RData = rdata0_q;
  assign bus.m1RData = rdata1_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed self-checking bench for rv32_bus_arbiter: handshake latency, round-robin,
// timeout, ready-on-last-cycle and mid-transfer reset.
module tb_rv32_bus_arbiter;

  logic clk;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  rv32_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv32_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit master, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
    if (master) begin
      bus.m1Req   = req;
      bus.m1We    = we;
      bus.m1Addr  = addr;
      bus.m1WData = wdata;
    end else begin
      bus.m0Req   = req;
      bus.m0We    = we;
      bus.m0Addr  = addr;
      bus.m0WData = wdata;
    end
  endtask

  task automatic slave_drive(input logic ready, input logic [31:0] rdata);
    bus.sReady = ready;
    bus.sRData = rdata;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " sReq"},    bus.sReq,    0);
    check_output({tag, " sWe"},     bus.sWe,     0);
    check_output({tag, " sAddr"},   bus.sAddr,   0);
    check_output({tag, " sWData"},  bus.sWData,  0);
    check_output({tag, " m0RData"}, bus.m0RData, 0);
    check_output({tag, " m1RData"}, bus.m1RData, 0);
    check_output({tag, " m0Ready"}, bus.m0Ready, 0);
    check_output({tag, " m1Ready"}, bus.m1Ready, 0);
    check_output({tag, " m0Err"},   bus.m0Err,   0);
    check_output({tag, " m1Err"},   bus.m1Err,   0);
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();
    tick();
    check_all_zero("reset");

    $display("[TB] write from m0, zero-wait slave");
    reset = 1'b1;
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678);
    tick();
    check_output("t1 sReq",    bus.sReq,    1);
    check_output("t1 sWe",     bus.sWe,     1);
    check_output("t1 sAddr",   bus.sAddr,   32'h1000_0004);
    check_output("t1 sWData",  bus.sWData,  32'h1234_5678);
    check_output("t1 early m0Ready", bus.m0Ready, 0);
    slave_drive(1'b1, 32'h0);
    tick();
    check_output("t1 m0Ready", bus.m0Ready, 1);
    check_output("t1 m0Err",   bus.m0Err,   0);
    check_output("t1 m1Ready", bus.m1Ready, 0);
    check_output("t1 resp sReq", bus.sReq,  0);
    check_output("t1 resp sWe",  bus.sWe,   0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();
    check_output("t1 single pulse", bus.m0Ready, 0);

    $display("[TB] read from m1 with two wait states");
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h2000_0008, 32'h0);
    tick();
    check_output("t2 sReq",  bus.sReq,  1);
    check_output("t2 sWe",   bus.sWe,   0);
    check_output("t2 sAddr", bus.sAddr, 32'h2000_0008);
    tick();
    check_output("t2 wait1 sReq", bus.sReq, 1);
    tick();
    check_output("t2 wait2 sReq", bus.sReq, 1);
    check_output("t2 wait2 m1Ready", bus.m1Ready, 0);
    slave_drive(1'b1, 32'hCAFE_F00D);
    tick();
    check_output("t2 m1Ready", bus.m1Ready, 1);
    check_output("t2 m1RData", bus.m1RData, 32'hCAFE_F00D);
    check_output("t2 m1Err",   bus.m1Err,   0);
    check_output("t2 m0Ready", bus.m0Ready, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();
    check_output("t2 m1Ready drop", bus.m1Ready, 0);
    check_output("t2 m1RData hold", bus.m1RData, 32'hCAFE_F00D);

    $display("[TB] both masters requesting from reset release");
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    slave_drive(1'b1, 32'h0BAD_F00D);
    tick();
    check_output("t3 reset m1RData", bus.m1RData, 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("t3 grant addr", bus.sAddr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      tick();
      check_output("t3 m0Ready", bus.m0Ready, (k % 2 == 0) ? 1 : 0);
      check_output("t3 m1Ready", bus.m1Ready, (k % 2 == 1) ? 1 : 0);
      check_output("t3 rdata", (k % 2 == 0) ? bus.m0RData : bus.m1RData, 32'h0BAD_F00D);
      tick();
      check_output("t3 idle m0Ready", bus.m0Ready, 0);
      check_output("t3 idle m1Ready", bus.m1Ready, 0);
      check_output("t3 idle sReq",    bus.sReq,    0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();
    check_output("t3 quiet sReq", bus.sReq, 0);

    $display("[TB] dead slave timeout on m0");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check_output("t4 busy sReq", bus.sReq, 1);
      check_output("t4 busy m0Ready", bus.m0Ready, 0);
      tick();
    end
    check_output("t4 end sReq", bus.sReq,    0);
    check_output("t4 m0Ready",  bus.m0Ready, 1);
    check_output("t4 m0Err",    bus.m0Err,   1);
    check_output("t4 m0RData",  bus.m0RData, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_output("t4 err drop", bus.m0Err, 0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'h55AA_55AA);
    tick();
    check_output("t4 retry sWData", bus.sWData, 32'h55AA_55AA);
    slave_drive(1'b1, 32'h0);
    tick();
    check_output("t4 retry m0Ready", bus.m0Ready, 1);
    check_output("t4 retry m0Err",   bus.m0Err,   0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();

    $display("[TB] slave ready on the last BUSY cycle");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h5000_0000, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    check_output("t5 last cycle sReq", bus.sReq, 1);
    slave_drive(1'b1, 32'h600D_DA7A);
    tick();
    check_output("t5 m0Ready", bus.m0Ready, 1);
    check_output("t5 m0Err",   bus.m0Err,   0);
    check_output("t5 m0RData", bus.m0RData, 32'h600D_DA7A);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();

    $display("[TB] reset during a BUSY transfer");
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0B00, 32'h0000_00BB);
    tick();
    check_output("t6 busy sReq", bus.sReq, 1);
    reset = 1'b0;
    tick();
    check_all_zero("t6 in reset");
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
    slave_drive(1'b1, 32'h0000_0077);
    tick();
    check_output("t6 no m1Ready", bus.m1Ready, 0);
    check_output("t6 no m0Ready", bus.m0Ready, 0);
    reset = 1'b1;
    tick();
    check_output("t6 first grant", bus.sAddr, 32'h0000_0A00);
    tick();
    check_output("t6 m0Ready", bus.m0Ready, 1);
    check_output("t6 m1Ready", bus.m1Ready, 0);
    check_output("t6 m0RData", bus.m0RData, 32'h0000_0077);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    slave_drive(1'b0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
